// File: rtl/enc_frame_tx.sv
// enc_frame_tx: framed plaintext byte source for verify. Each byte is encrypted in S1
// and hashed into S2; frames optionally close with an XOR-digest trailer beat.
module enc_frame_tx #(
    parameter int unsigned MAX_LEN      = 64,
    parameter bit          EMIT_TRAILER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_plain,
    output logic [7:0]  out_cipher,
    output logic [7:0]  out_hash,
    output logic        out_trailer,
    output logic        out_last,
    output logic        out_err,
    output logic [15:0] frames_sent,
    output logic [1:0]  fsm_state
);

    // Handshake: a beat moves on the rising edge where valid && ready are both high.
    // valid never depends on ready, and a presented beat holds steady until it moves.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FRAME   = 2'd1,
        TRAILER = 2'd2
    } state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    function automatic logic [7:0] encrypt_byte(input logic [7:0] p);
        return {p[3:0], p[7:4]} ^ 8'hA5;
    endfunction

    function automatic logic [7:0] hash_byte(input logic [7:0] c);
        return c + 8'h3C;
    endfunction

    state_t      state;
    state_t      state_next;

    logic        s1_valid;
    logic [7:0]  s1_plain;
    logic [7:0]  s1_cipher;
    logic        s1_last;
    logic        s1_trailer;
    logic        s1_err;

    logic [7:0]  digest;
    logic [15:0] len;
    logic        trail_err;

    logic        s2_load;
    logic        s1_load_ok;
    logic        s1_advance;
    logic        accept;
    logic        trailer_load;
    logic [15:0] len_next;
    logic        hit_max;
    logic        final_byte;
    logic        forced;

    always_comb begin
        s2_load      = !out_valid || out_ready;
        s1_advance   = s1_valid && s2_load;
        s1_load_ok   = !s1_valid || s2_load;
        in_ready     = s1_load_ok && (state != TRAILER);
        accept       = in_valid && in_ready;
        len_next     = len + 16'd1;
        hit_max      = (len_next == MAX_LEN_W);
        final_byte   = in_last || hit_max;
        forced       = hit_max && !in_last;
        trailer_load = (state == TRAILER) && s1_load_ok;
        state_next   = state;
        case (state)
            IDLE, FRAME: begin
                if (accept) begin
                    if (final_byte) state_next = EMIT_TRAILER ? TRAILER : IDLE;
                    else            state_next = FRAME;
                end
            end
            TRAILER: if (trailer_load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // S1: a data byte and the trailer never compete, since input is closed in TRAILER.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_plain   <= 8'd0;
            s1_cipher  <= 8'd0;
            s1_last    <= 1'b0;
            s1_trailer <= 1'b0;
            s1_err     <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_plain   <= in_data;
            s1_cipher  <= encrypt_byte(in_data);
            s1_last    <= final_byte && !EMIT_TRAILER;
            s1_trailer <= 1'b0;
            s1_err     <= forced;
        end else if (trailer_load) begin
            s1_valid   <= 1'b1;
            s1_plain   <= digest;
            s1_cipher  <= encrypt_byte(digest);
            s1_last    <= 1'b1;
            s1_trailer <= 1'b1;
            s1_err     <= trail_err;
        end else if (s1_advance) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digest    <= 8'd0;
            len       <= 16'd0;
            trail_err <= 1'b0;
        end else if (accept) begin
            if (final_byte && !EMIT_TRAILER) begin
                digest <= 8'd0;
                len    <= 16'd0;
            end else begin
                digest <= digest ^ in_data;
                len    <= len_next;
            end
            trail_err <= forced;
        end else if (trailer_load) begin
            digest    <= 8'd0;
            len       <= 16'd0;
            trail_err <= 1'b0;
        end
    end

    // S2 keeps its payload when it empties so the port only changes on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_plain   <= 8'd0;
            out_cipher  <= 8'd0;
            out_hash    <= 8'd0;
            out_trailer <= 1'b0;
            out_last    <= 1'b0;
            out_err     <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_plain   <= s1_plain;
                out_cipher  <= s1_cipher;
                out_hash    <= hash_byte(s1_cipher);
                out_trailer <= s1_trailer;
                out_last    <= s1_last;
                out_err     <= s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                  frames_sent <= 16'd0;
        else if (out_valid && out_ready && out_last) frames_sent <= frames_sent + 16'd1;
    end

endmodule
